// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the stack calculator.
//   op_e    : 3-bit command opcode
//   state_e : controller FSM state
package calc_pkg;

  typedef enum logic [2:0] {
    OP_PUSH  = 3'd0,
    OP_POP   = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_DUP   = 3'd4,
    OP_SWAP  = 3'd5,
    OP_CLEAR = 3'd6,
    OP_MUL   = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/lifo_mem.sv
// lifo_mem: DEPTH x WIDTH stack storage.
//   Asynchronous read of TOS (entry depth-1) and NOS (entry depth-2); a read
//   of a non-existent entry returns 0, so an empty stack shows top 0 no
//   matter what the (unreset) array holds.
//   One write port (i_we/i_waddr/i_wdata). i_swap is a dedicated strobe that
//   exchanges TOS and NOS in one edge; it takes priority over i_we.
// Ports:
//   clk      : clock, writes on rising edge
//   i_depth  : current entry count, selects TOS/NOS
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_swap   : exchange TOS and NOS
//   o_tos    : top of stack (0 when depth < 1)
//   o_nos    : next on stack (0 when depth < 2)
module lifo_mem #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [CW-1:0]    i_depth,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_swap,
  output logic [WIDTH-1:0] o_tos,
  output logic [WIDTH-1:0] o_nos
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    w_tos_idx;
  logic [AW-1:0]    w_nos_idx;

  assign w_tos_idx = AW'(i_depth - CW'(1));
  assign w_nos_idx = AW'(i_depth - CW'(2));

  always_comb begin
    o_tos = '0;
    o_nos = '0;
    if (i_depth >= CW'(1)) o_tos = r_mem[w_tos_idx];
    if (i_depth >= CW'(2)) o_nos = r_mem[w_nos_idx];
  end

  // Contents are deliberately not reset; they are masked while depth is 0.
  always_ff @(posedge clk) begin
    if (i_swap) begin
      r_mem[w_tos_idx] <= o_nos;
      r_mem[w_nos_idx] <= o_tos;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/stack_calculator.sv
// stack_calculator: command-driven integer stack calculator.
//   A command is accepted in IDLE (cmd_valid & cmd_ready), latched, and
//   executed on the following (EXEC) clock edge; results are visible the
//   cycle after EXEC. One command per two cycles, no queueing.
//   Illegal commands set the sticky err flag and leave stack/depth/carry
//   untouched; CLEAR empties the stack and clears err and carry.
// Build option:
//   STACK_CALCULATOR_MUL_EN : when defined, opcode 7 is MUL; otherwise opcode
//                             7 is illegal and no multiplier is built.
// Ports:
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   cmd_valid : command offered
//   cmd_op    : opcode (calc_pkg::op_e)
//   cmd_data  : PUSH operand
//   cmd_ready : high in IDLE, command accepted when cmd_valid & cmd_ready
//   top       : top-of-stack value, 0 when empty
//   depth     : current entry count
//   carry     : carry / borrow / high-product flag of last arithmetic op
//   err       : sticky error flag
//   idle      : high in IDLE
//
// state   | meaning
// --------+------------------------------------------------------
// ST_IDLE | waiting for a command, cmd_ready high
// ST_EXEC | latched command commits to stack/flags on next edge
module stack_calculator
  import calc_pkg::*;
#(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    depth,
  output logic             carry,
  output logic             err,
  output logic             idle
);

  localparam int AW = $clog2(DEPTH);

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              r_op;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_depth;
  logic [CW-1:0]    w_depth_nxt;
  logic             r_carry;
  logic             w_carry_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_accept;
  logic             w_we;
  logic             w_swap;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_tos;
  logic [WIDTH-1:0] w_nos;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_full;
  logic             w_ge1;
  logic             w_ge2;

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_depth (r_depth),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_swap  (w_swap),
    .o_tos   (w_tos),
    .o_nos   (w_nos)
  );

  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_full   = (r_depth == CW'(DEPTH));
  assign w_ge1    = (r_depth != '0);
  assign w_ge2    = (r_depth >= CW'(2));

  // Extra MSB captures ADD carry-out and, for SUB, the borrow (NOS < TOS).
  assign w_sum  = {1'b0, w_nos} + {1'b0, w_tos};
  assign w_diff = {1'b0, w_nos} - {1'b0, w_tos};

`ifdef STACK_CALCULATOR_MUL_EN
  logic [2*WIDTH-1:0] w_prod;
  assign w_prod = (2*WIDTH)'(w_nos) * (2*WIDTH)'(w_tos);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_PUSH;
      r_data <= '0;
    end else if (w_accept) begin
      r_op   <= op_e'(cmd_op);
      r_data <= cmd_data;
    end
  end

  // Execution: only acts in EXEC, so a reset that drops the FSM to IDLE
  // also cancels the write of an in-flight command.
  always_comb begin
    w_depth_nxt = r_depth;
    w_carry_nxt = r_carry;
    w_err_nxt   = r_err;
    w_we        = 1'b0;
    w_swap      = 1'b0;
    w_waddr     = AW'(r_depth);
    w_wdata     = r_data;
    if (r_state == ST_EXEC) begin
      case (r_op)
        OP_PUSH: begin
          if (w_full) w_err_nxt = 1'b1;
          else begin
            w_we        = 1'b1;
            w_depth_nxt = r_depth + CW'(1);
          end
        end
        OP_POP: begin
          if (!w_ge1) w_err_nxt = 1'b1;
          else        w_depth_nxt = r_depth - CW'(1);
        end
        OP_ADD: begin
          if (!w_ge2) w_err_nxt = 1'b1;
          else begin
            w_we        = 1'b1;
            w_waddr     = AW'(r_depth - CW'(2));
            w_wdata     = w_sum[WIDTH-1:0];
            w_carry_nxt = w_sum[WIDTH];
            w_depth_nxt = r_depth - CW'(1);
          end
        end
        OP_SUB: begin
          if (!w_ge2) w_err_nxt = 1'b1;
          else begin
            w_we        = 1'b1;
            w_waddr     = AW'(r_depth - CW'(2));
            w_wdata     = w_diff[WIDTH-1:0];
            w_carry_nxt = w_diff[WIDTH];
            w_depth_nxt = r_depth - CW'(1);
          end
        end
`ifdef STACK_CALCULATOR_MUL_EN
        OP_MUL: begin
          if (!w_ge2) w_err_nxt = 1'b1;
          else begin
            w_we        = 1'b1;
            w_waddr     = AW'(r_depth - CW'(2));
            w_wdata     = w_prod[WIDTH-1:0];
            w_carry_nxt = |w_prod[2*WIDTH-1:WIDTH];
            w_depth_nxt = r_depth - CW'(1);
          end
        end
`endif
        OP_DUP: begin
          // w_tos reads 0 on an empty stack, so DUP of empty pushes 0.
          if (w_full) w_err_nxt = 1'b1;
          else begin
            w_we        = 1'b1;
            w_wdata     = w_tos;
            w_depth_nxt = r_depth + CW'(1);
          end
        end
        OP_SWAP: begin
          if (!w_ge2) w_err_nxt = 1'b1;
          else        w_swap    = 1'b1;
        end
        OP_CLEAR: begin
          w_depth_nxt = '0;
          w_carry_nxt = 1'b0;
          w_err_nxt   = 1'b0;
        end
        // Reached by opcode 7 when the multiplier is not built.
        default: w_err_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_depth <= w_depth_nxt;
      r_carry <= w_carry_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign idle      = (r_state == ST_IDLE);
  assign top       = w_tos;
  assign depth     = r_depth;
  assign carry     = r_carry;
  assign err       = r_err;

endmodule

// File: doc/stack_calculator.md
STACK_CALCULATOR -- requirements
Module: stack_calculator

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand/result width in bits (>=2).
REQ-002 SHALL have parameter DEPTH, default 8, maximum stack entries (>=2); CW = $clog2(DEPTH+1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_op  input  3  opcode: 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 DUP, 5 SWAP, 6 CLEAR, 7 MUL.
REQ-007 SHALL have port cmd_data  input  WIDTH  PUSH operand.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-009 SHALL have port top  output  WIDTH  top-of-stack value, 0 when empty.
REQ-010 SHALL have port depth  output  CW  current entry count.
REQ-011 SHALL have port carry  output  1  carry/borrow/high-product flag of last arithmetic op.
REQ-012 SHALL have port err  output  1  sticky error flag.
REQ-013 SHALL have port idle  output  1  high in IDLE state (drives the idle LED).

Function
REQ-014 FSM SHALL have states IDLE and EXEC; IDLE->EXEC on accept, EXEC->IDLE unconditionally.
REQ-015 cmd_ready SHALL equal 1 in IDLE, 0 in EXEC; opcode/data SHALL be latched on accept.
REQ-016 Stack update SHALL commit at the EXEC clock edge; top/depth/carry/err valid the cycle after EXEC (2-cycle latency, 1 command per 2 cycles).
REQ-017 PUSH SHALL write cmd_data as new top, depth+1; POP SHALL drop top, depth-1.
REQ-018 ADD/SUB/MUL SHALL replace top two entries (NOS, TOS) with NOS op TOS mod 2^WIDTH, depth-1; SUB = NOS-TOS.
REQ-019 carry SHALL be: ADD carry-out; SUB borrow (NOS<TOS); MUL OR of product bits above WIDTH-1; unchanged by other ops.
REQ-020 DUP SHALL push a copy of TOS; SWAP SHALL exchange TOS and NOS, depth unchanged.
REQ-021 CLEAR SHALL set depth=0, err=0, carry=0; always legal.
REQ-022 Illegal op (PUSH/DUP at depth==DEPTH; POP at depth 0; ADD/SUB/MUL/SWAP at depth<2; MUL when compiled out) SHALL set err=1 and leave stack, depth, carry unchanged.
REQ-023 err SHALL remain set until CLEAR or reset; subsequent legal ops SHALL still execute.
REQ-024 depth SHALL never exceed DEPTH nor underflow below 0.
REQ-025 cmd_valid while cmd_ready=0 SHALL be ignored; no command queueing.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, depth=0, top=0, carry=0, err=0, cmd_ready=1, idle=1, including mid-EXEC (in-flight command discarded).
REQ-027 Stack storage contents need not be reset; they SHALL be unobservable while depth is 0.

Configuration
REQ-028 Macro STACK_CALCULATOR_MUL_EN defined: opcode 7 SHALL perform MUL per REQ-018/019.
REQ-029 Macro undefined: opcode 7 SHALL be illegal per REQ-022 and no multiplier SHALL be synthesised.

Structure
REQ-030 Package calc_pkg SHALL hold the opcode enumeration and FSM state typedef.
REQ-031 Storage SHALL be sub-module lifo_mem (DEPTH x WIDTH, async read of TOS/NOS at depth-1/depth-2, single-port write); FSM, ALU, flags in stack_calculator.

Verification (WIDTH=5, DEPTH=4)
REQ-032 PUSH 3, PUSH 4, ADD -> top=7, depth=1, carry=0, err=0; each cmd_ready low exactly 1 cycle.
REQ-033 PUSH 20, PUSH 15, ADD -> top=3, carry=1; PUSH 2, PUSH 5, SUB -> top=29, carry=1.
REQ-034 PUSH 1,2,3,4 then PUSH 9 -> err=1, depth=4, top=4; CLEAR -> depth=0, top=0, err=0.
REQ-035 PUSH 6, ADD -> err=1, depth=1, top=6; PUSH 7, SWAP -> top=6, depth=2.
REQ-036 PUSH 6, PUSH 7, MUL -> with macro top=10, carry=1; without macro err=1, top=7, depth=2.
REQ-037 rst_n low during EXEC of PUSH 5 -> same cycle depth=0, top=0, idle=1; after release, PUSH is not applied.
